// File: rtl/fft_ctrl_pkg.sv
// Shared state encoding, sizes and rotator select codes for the FFT address/control sequencer.
package fft_ctrl_pkg;

    localparam int LOG2N = 5;
    localparam int N     = 32;
    localparam int NBF   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_OUTPUT,
        ST_DONE
    } state_t;

    localparam logic [2:0] ROT_L1 = 3'd0;
    localparam logic [2:0] ROT_L2 = 3'd1;
    localparam logic [2:0] ROT_L3 = 3'd2;
    localparam logic [2:0] ROT_L4 = 3'd3;

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
        return r;
    endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Fixed-latency write-back delay line: replays each accepted butterfly issue DEPTH cycles later.
module fft_wb_delay #(
    parameter int DEPTH = 3,
    parameter int W     = 11
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe [DEPTH];

    // Never stalls; clr flushes every slot so no stale write-back escapes.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/fft_addr_seq.sv
// Stage/butterfly sequencer for the 32-point radix-2 DIF FFT: issue, drain, bit-reversed readout.
module fft_addr_seq #(
    parameter int LOG2N    = 5,
    parameter int PIPE_LAT = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             bf_ready,
    output logic             rd_valid,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_idx,
    output logic             rot_clr,
    output logic [2:0]       rot_sel,
    output logic             wr_valid,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic             out_valid,
    output logic [LOG2N-1:0] out_addr,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);
    import fft_ctrl_pkg::*;

    localparam int WBW = 2 * LOG2N + 1;

    state_t           state, state_nxt;
    logic [2:0]       stage;
    logic [LOG2N-2:0] bf;
    logic [LOG2N-1:0] k;
    logic [2:0]       drain;

    logic issue_acc, out_acc, drain_end, last_stage;
    logic [LOG2N-1:0] span, mask, j_ext;
    logic [WBW-1:0]   wb_in, wb_out;

    assign issue_acc  = rd_valid & bf_ready;
    assign out_acc    = out_valid & out_ready;
    assign drain_end  = (drain == 3'(PIPE_LAT - 1));
    assign last_stage = (stage == 3'(LOG2N - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_ISSUE;
            ST_ISSUE:  if (issue_acc && bf == (LOG2N-1)'(NBF - 1)) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (drain_end) state_nxt = last_stage ? ST_OUTPUT : ST_ISSUE;
            ST_OUTPUT: if (out_acc && k == LOG2N'(N - 1)) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // j and k wrap naturally at their last value, so they are already 0 for the next stage/phase.
    always_ff @(posedge clk) begin
        if (clr) begin
            stage <= '0;
            bf    <= '0;
            k     <= '0;
            drain <= '0;
        end else begin
            case (state)
                ST_ISSUE: begin
                    drain <= '0;
                    if (issue_acc) bf <= bf + 1'b1;
                end
                ST_DRAIN: begin
                    if (drain_end) begin
                        drain <= '0;
                        if (!last_stage) stage <= stage + 1'b1;
                    end else begin
                        drain <= drain + 1'b1;
                    end
                end
                ST_OUTPUT: if (out_acc) k <= k + 1'b1;
                default: begin
                    stage <= '0;
                    bf    <= '0;
                    k     <= '0;
                    drain <= '0;
                end
            endcase
        end
    end

    // Splicing a zero in at bit (4-s) is the same as shifting the high part of j up by one.
    assign span  = {1'b1, {(LOG2N-1){1'b0}}} >> stage;
    assign mask  = span - 1'b1;
    assign j_ext = {1'b0, bf};

    assign rd_valid  = (state == ST_ISSUE);
    assign rd_addr_a = rd_valid ? (((j_ext & ~mask) << 1) | (j_ext & mask)) : '0;
    assign rd_addr_b = rd_valid ? (rd_addr_a + span) : '0;
    assign tw_idx    = rd_valid ? ((bf & mask[LOG2N-2:0]) << stage) : '0;

    always_comb begin
        rot_clr = 1'b1;
        rot_sel = ROT_L1;
        if ((state == ST_ISSUE || state == ST_DRAIN) && stage != 3'd0) begin
            rot_clr = 1'b0;
            case (stage)
                3'd1:    rot_sel = ROT_L1;
                3'd2:    rot_sel = ROT_L2;
                3'd3:    rot_sel = ROT_L3;
                default: rot_sel = ROT_L4;
            endcase
        end
    end

    assign wb_in = issue_acc ? {1'b1, rd_addr_a, rd_addr_b} : '0;

    fft_wb_delay #(
        .DEPTH(PIPE_LAT),
        .W    (WBW)
    ) u_wb_delay (
        .clk (clk),
        .clr (clr),
        .din (wb_in),
        .dout(wb_out)
    );

    assign {wr_valid, wr_addr_a, wr_addr_b} = wb_out;

    assign out_valid = (state == ST_OUTPUT);
    assign out_addr  = out_valid ? bitrev5(k) : '0;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_fft_addr_seq.sv
// Randomized self-checking bench for fft_addr_seq against a formula-level model of the FFT schedule.
module tb_fft_addr_seq;

    localparam int PL = 3;

    logic       clk = 1'b0;
    logic       clr, start, bf_ready, out_ready;
    logic       rd_valid, rot_clr, wr_valid, out_valid, busy, done;
    logic [4:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, out_addr;
    logic [3:0] tw_idx;
    logic [2:0] rot_sel;

    fft_addr_seq #(.LOG2N(5), .PIPE_LAT(PL)) dut (
        .clk(clk), .clr(clr), .start(start), .bf_ready(bf_ready),
        .rd_valid(rd_valid), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
        .rot_clr(rot_clr), .rot_sel(rot_sel),
        .wr_valid(wr_valid), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .out_valid(out_valid), .out_addr(out_addr), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int due; int a; int b; } wr_t;
    wr_t wq[$];

    int la [80];
    int lb [80];
    int ltw[80];
    int lo [32];
    int t0, done_cyc, idle_cyc, first_issue_cyc;
    int wr_count, done_count, out_count, issue_count;

    function automatic int ref_a(int s, int j);
        int span = 16 >> s;
        return ((j >> (4 - s)) << (5 - s)) | (j & (span - 1));
    endfunction

    function automatic int ref_b(int s, int j);
        return ref_a(s, j) + (16 >> s);
    endfunction

    function automatic int ref_tw(int s, int j);
        return ((j & ((16 >> s) - 1)) << s) & 15;
    endfunction

    function automatic int ref_rev(int v);
        int r = 0;
        for (int i = 0; i < 5; i++) r |= ((v >> i) & 1) << (4 - i);
        return r;
    endfunction

    // bf_mode: 0 high, 1 random, 2 four-cycle stall at s=2 j=7; out_mode: 0 high, 1 toggle, 2 random.
    task automatic run_transform(input int bf_mode, input int out_mode, input int clr_stage,
                                 input bit extra_start);
        int  n, m, stall_cnt, s, j, ea, eb, etw;
        bit  finished, aborted, prev_stall;
        logic [4:0] pa, pb;
        logic [3:0] ptw;
        n = 0; m = 0; stall_cnt = 0;
        finished = 0; aborted = 0; prev_stall = 0;
        pa = '0; pb = '0; ptw = '0;
        wr_count = 0; done_count = 0; done_cyc = -1; idle_cyc = -1; first_issue_cyc = -1;
        wq.delete();
        @(negedge clk);
        t0 = cyc;
        start = 1'b1; bf_ready = 1'b1; out_ready = 1'b1;
        checks++;
        if (busy !== 1'b0 || rd_valid !== 1'b0)
            $display("[TB] FAIL idle_before_start busy=%0b rd_valid=%0b required 0 0", busy, rd_valid);
        if (busy !== 1'b0 || rd_valid !== 1'b0) errors++;
        for (int budget = 0; budget < 3000 && !finished; budget++) begin
            @(negedge clk);
            start = extra_start && (cyc == t0 + 50 || done === 1'b1);
            case (bf_mode)
                0: bf_ready = 1'b1;
                1: bf_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    bf_ready = 1'b1;
                    if (rd_valid === 1'b1 && n == 39 && stall_cnt < 4) begin
                        bf_ready = 1'b0;
                        stall_cnt++;
                    end
                end
            endcase
            case (out_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = ($urandom_range(0, 1) != 0);
            endcase

            checks++;
            if (wq.size() > 0 && wq[0].due == cyc) begin
                if (wr_valid !== 1'b1 || wr_addr_a !== 5'(wq[0].a) || wr_addr_b !== 5'(wq[0].b)) begin
                    errors++;
                    $display("[TB] FAIL wr_pair cyc=%0d got v=%0b a=%0d b=%0d required v=1 a=%0d b=%0d",
                             cyc, wr_valid, wr_addr_a, wr_addr_b, wq[0].a, wq[0].b);
                end
                void'(wq.pop_front());
            end else if (wr_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL wr_spurious cyc=%0d got wr_valid=%0b required 0", cyc, wr_valid);
            end
            if (wr_valid === 1'b1) wr_count++;

            if (prev_stall) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_addr_a !== pa || rd_addr_b !== pb || tw_idx !== ptw) begin
                    errors++;
                    $display("[TB] FAIL stall_hold got v=%0b a=%0d b=%0d tw=%0d required v=1 a=%0d b=%0d tw=%0d",
                             rd_valid, rd_addr_a, rd_addr_b, tw_idx, pa, pb, ptw);
                end
            end

            prev_stall = 1'b0;
            if (rd_valid === 1'b1) begin
                if (first_issue_cyc < 0) first_issue_cyc = cyc;
                checks++;
                if (n >= 80) begin
                    errors++;
                    $display("[TB] FAIL extra_issue got issue number %0d required at most 80", n + 1);
                end else if (bf_ready) begin
                    s = n / 16; j = n % 16;
                    ea = ref_a(s, j); eb = ref_b(s, j); etw = ref_tw(s, j);
                    if (rd_addr_a !== 5'(ea) || rd_addr_b !== 5'(eb) || tw_idx !== 4'(etw)) begin
                        errors++;
                        $display("[TB] FAIL issue_addr s=%0d j=%0d got a=%0d b=%0d tw=%0d required a=%0d b=%0d tw=%0d",
                                 s, j, rd_addr_a, rd_addr_b, tw_idx, ea, eb, etw);
                    end
                    checks++;
                    if (rot_clr !== (s == 0) || (s != 0 && rot_sel !== 3'(s - 1))) begin
                        errors++;
                        $display("[TB] FAIL rot_ctrl s=%0d got clr=%0b sel=%0d required clr=%0b sel=%0d",
                                 s, rot_clr, rot_sel, (s == 0), (s == 0) ? 0 : s - 1);
                    end
                    la[n] = int'(rd_addr_a); lb[n] = int'(rd_addr_b); ltw[n] = int'(tw_idx);
                    wq.push_back('{cyc + PL, ea, eb});
                    n++;
                end else begin
                    prev_stall = 1'b1;
                    pa = rd_addr_a; pb = rd_addr_b; ptw = tw_idx;
                end
            end

            if (out_valid === 1'b1) begin
                checks++;
                if (n != 80 || wq.size() != 0 || m >= 32 || rot_clr !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL output_phase_entry got issues=%0d pending_wr=%0d k=%0d rot_clr=%0b required 80 0 <32 1",
                             n, wq.size(), m, rot_clr);
                end
                if (out_ready) begin
                    checks++;
                    if (out_addr !== 5'(ref_rev(m))) begin
                        errors++;
                        $display("[TB] FAIL out_addr k=%0d got %0d required %0d", m, out_addr, ref_rev(m));
                    end
                    if (m < 32) lo[m] = int'(out_addr);
                    m++;
                end
            end

            checks++;
            if ((rd_valid === 1'b1 || out_valid === 1'b1 || done === 1'b1) && busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL busy_active got busy=%0b required 1", busy);
            end

            if (done === 1'b1) begin
                done_count++;
                done_cyc = cyc;
                checks++;
                if (m != 32 || wq.size() != 0) begin
                    errors++;
                    $display("[TB] FAIL done_early got accepted_out=%0d pending_wr=%0d required 32 0", m, wq.size());
                end
                finished = 1;
            end

            if (!finished && clr_stage >= 0 && n == (clr_stage + 1) * 16 && rd_valid === 1'b0
                && busy === 1'b1) begin
                clr = 1'b1;
                start = 1'b1;
                aborted = 1;
                finished = 1;
            end
        end
        issue_count = n;
        out_count = m;
        checks++;
        if (!finished) begin
            errors++;
            $display("[TB] FAIL timeout got no completion within 3000 cycles required done");
        end
        @(negedge clk);
        clr = 1'b0;
        start = 1'b0;
        idle_cyc = cyc;
        checks++;
        if (busy !== 1'b0 || rd_valid !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL back_to_idle got busy=%0b rd=%0b out=%0b done=%0b required 0 0 0 0",
                     busy, rd_valid, out_valid, done);
        end
        if (aborted) begin
            checks++;
            if (rd_addr_a !== 5'd0 || rd_addr_b !== 5'd0 || tw_idx !== 4'd0 || rot_clr !== 1'b1
                || rot_sel !== 3'd0 || wr_valid !== 1'b0 || out_addr !== 5'd0) begin
                errors++;
                $display("[TB] FAIL clr_outputs got a=%0d b=%0d tw=%0d rc=%0b rs=%0d wv=%0b oa=%0d required 0 0 0 1 0 0 0",
                         rd_addr_a, rd_addr_b, tw_idx, rot_clr, rot_sel, wr_valid, out_addr);
            end
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                checks++;
                if (wr_valid !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL clr_flush cyc=%0d got wr_valid=%0b busy=%0b required 0 0", cyc, wr_valid, busy);
                end
            end
        end
    endtask

    task automatic test_reset;
        clr = 1'b1; start = 1'b1; bf_ready = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_addr_a !== 5'd0 || rd_addr_b !== 5'd0 || tw_idx !== 4'd0
            || rot_clr !== 1'b1 || rot_sel !== 3'd0 || wr_valid !== 1'b0 || wr_addr_a !== 5'd0
            || wr_addr_b !== 5'd0 || out_valid !== 1'b0 || out_addr !== 5'd0 || busy !== 1'b0
            || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values got rd=%0b a=%0d b=%0d tw=%0d rc=%0b rs=%0d busy=%0b required 0 0 0 0 1 0 0",
                     rd_valid, rd_addr_a, rd_addr_b, tw_idx, rot_clr, rot_sel, busy);
        end
        start = 1'b0;
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stage_addr;
        run_transform(0, 0, -1, 0);
        checks++;
        if (la[0] != 0 || lb[0] != 16 || ltw[0] != 0 || la[5] != 5 || lb[5] != 21) begin
            errors++;
            $display("[TB] FAIL stage0_addr got %0d/%0d/%0d %0d/%0d required 0/16/0 5/21",
                     la[0], lb[0], ltw[0], la[5], lb[5]);
        end
        checks++;
        if (la[25] != 17 || lb[25] != 25 || ltw[25] != 2 || la[67] != 6 || lb[67] != 7 || ltw[67] != 0) begin
            errors++;
            $display("[TB] FAIL stage1_4_addr got %0d/%0d/%0d %0d/%0d/%0d required 17/25/2 6/7/0",
                     la[25], lb[25], ltw[25], la[67], lb[67], ltw[67]);
        end
    endtask

    task automatic test_stall;
        run_transform(2, 0, -1, 0);
        checks++;
        if (wr_count != 80 || issue_count != 80) begin
            errors++;
            $display("[TB] FAIL stall_counts got wr=%0d issues=%0d required 80 80", wr_count, issue_count);
        end
        checks++;
        if (la[39] != 11 || lb[39] != 15 || ltw[39] != 12) begin
            errors++;
            $display("[TB] FAIL stall_point got %0d/%0d/%0d required 11/15/12", la[39], lb[39], ltw[39]);
        end
    endtask

    task automatic test_output_phase;
        run_transform(0, 1, -1, 0);
        checks++;
        if (lo[1] != 16 || lo[6] != 12 || out_count != 32 || done_count != 1) begin
            errors++;
            $display("[TB] FAIL output_phase got k1=%0d k6=%0d outs=%0d dones=%0d required 16 12 32 1",
                     lo[1], lo[6], out_count, done_count);
        end
    endtask

    task automatic test_full_run;
        run_transform(0, 0, -1, 1);
        checks++;
        if (first_issue_cyc - t0 != 1 || done_cyc - t0 != 128 || idle_cyc - t0 != 129 || done_count != 1) begin
            errors++;
            $display("[TB] FAIL full_run_timing got first=%0d done=%0d idle=%0d dones=%0d required 1 128 129 1",
                     first_issue_cyc - t0, done_cyc - t0, idle_cyc - t0, done_count);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || rd_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL start_in_done_ignored got busy=%0b rd=%0b required 0 0", busy, rd_valid);
            end
        end
    endtask

    task automatic test_clr_drain;
        run_transform(0, 0, 3, 0);
        run_transform(0, 0, -1, 0);
        checks++;
        if (la[0] != 0 || lb[0] != 16 || done_count != 1 || wr_count != 80) begin
            errors++;
            $display("[TB] FAIL clr_restart got a=%0d b=%0d dones=%0d wr=%0d required 0 16 1 80",
                     la[0], lb[0], done_count, wr_count);
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 2; r++) begin
            run_transform(1, 2, -1, 0);
            checks++;
            if (wr_count != 80 || out_count != 32 || done_count != 1) begin
                errors++;
                $display("[TB] FAIL random_run got wr=%0d outs=%0d dones=%0d required 80 32 1",
                         wr_count, out_count, done_count);
            end
        end
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; bf_ready = 1'b0; out_ready = 1'b0;
        test_reset();
        test_stage_addr();
        test_stall();
        test_output_phase();
        test_full_run();
        test_clr_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_addr_seq.md
# fft_addr_seq

Address and control sequencer for the 32-point radix-2 DIF FFT core. Walks the 5 butterfly stages (16 butterflies each), issues read address pairs and twiddle indices to the butterfly unit, and issues matching write-back addresses after the butterfly pipeline latency. It drives the rotate-left bank-mapping unit per stage and then reads the result out in bit-reversed order. It sits between the top-level start/done handshake and the data RAM, butterfly and rotator.

## Interface
- LOG2N, 5, log2 of FFT size; only 5 is supported.
- PIPE_LAT, 3, butterfly latency in cycles from accepted issue to write-back (1..7).
- clk  in  1  clock.
- clr  in  1  synchronous active-high reset.
- start  in  1  begin a transform; sampled only in IDLE.
- bf_ready  in  1  butterfly accepts the current issue.
- rd_valid  out  1  issue valid.
- rd_addr_a / rd_addr_b  out  5  butterfly operand addresses.
- tw_idx  out  4  twiddle ROM index.
- rot_clr  out  1  rotator pass-through.
- rot_sel  out  3  rotator select: 0=rotl1, 1=rotl2, 2=rotl3, 3=rotl4.
- wr_valid  out  1  write-back strobe.
- wr_addr_a / wr_addr_b  out  5  write-back addresses.
- out_valid  out  1  output-phase read valid.
- out_addr  out  5  bit-reversed read address.
- out_ready  in  1  consumer accepts out_addr.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, ISSUE, DRAIN, OUTPUT, DONE.
  - IDLE→ISSUE on start; stage s=0, butterfly j=0.
  - ISSUE→DRAIN after the issue with j=15 is accepted.
  - DRAIN→ISSUE after PIPE_LAT cycles if s<4; s increments and j resets to 0.
  - DRAIN→OUTPUT after PIPE_LAT cycles if s=4; k=0.
  - OUTPUT→DONE after the out_addr with k=31 is accepted.
  - DONE→IDLE unconditionally.
- Issue is accepted when rd_valid&bf_ready. Otherwise j and all rd_* outputs hold.
- Address generation, with span = 16>>s:
  - rd_addr_a = ((j>>(4-s))<<(5-s)) | (j&(span-1)).
  - rd_addr_b = rd_addr_a + span.
  - tw_idx = (j&(span-1))<<s, truncated to 4 bits.
- Rotator control:
  - s=0: rot_clr=1.
  - s≥1: rot_clr=0, rot_sel=s-1.
  - OUTPUT: rot_clr=1.
  - rot_sel resets to 0.
- Write-back: every accepted issue produces wr_valid with the same address pair exactly PIPE_LAT cycles later. This pipeline is never stalled.
- OUTPUT: out_addr = bit-reverse(k). k advances when out_valid&out_ready.
- start while busy is ignored. start during the DONE cycle is ignored; it is accepted on the next cycle in IDLE.
- clr at any time, including mid-stage or mid-drain:
  - next state IDLE, all counters 0;
  - the write-back pipeline is flushed and no wr_valid is emitted afterwards.
  - clr wins over a simultaneous start.

## Timing
- Reset values: all outputs 0 except rot_clr=1.
- start sampled at cycle t0 → first rd_valid at t0+1.
- Each stage with bf_ready held high: 16 issue cycles plus PIPE_LAT drain cycles. The next stage's first read comes one cycle after the last write, which is RAW-safe for synchronous-write RAM.
- With bf_ready and out_ready held high, done pulses at t0+1+5*(16+PIPE_LAT)+32. For PIPE_LAT=3 that is t0+128.
- busy falls in the cycle after done.

## Structure
- Shared package fft_ctrl_pkg holds:
  - state enum;
  - LOG2N, N=32, NBF=16;
  - rotator select encodings.
- Sub-module fft_wb_delay: a PIPE_LAT-deep shift register of {valid, addr_a, addr_b} with synchronous clear.
- The FSM, the s/j/k counters and the address math stay in fft_addr_seq.

## Test plan
- Stage 0 address check: start with bf_ready=1.
  - j=0 → a=0, b=16, tw=0, rot_clr=1.
  - j=5 → a=5, b=21.
- Stages 1 and 4 address and rotator check:
  - s=1, j=9 → a=17, b=25, tw=2, rot_sel=0.
  - s=4, j=3 → a=6, b=7, tw=0, rot_sel=3.
- Stall: bf_ready low for 4 cycles at s=2, j=7 → outputs hold; wr_valid count stays exactly 80 per transform; each wr pair equals its rd pair delayed by PIPE_LAT.
- Output phase with out_ready toggling: k=1 → out_addr=16, k=6 → out_addr=12; 32 accepted addresses, then one done pulse.
- Full run, all ready signals high: done exactly at t0+128; busy low at t0+129; a second start during busy is ignored.
- clr asserted in DRAIN of stage 3 → next cycle IDLE with all outputs at reset values; no further wr_valid; a new start restarts from s=0, j=0.
